// File: rtl/avalon_agent_pkg.sv
// Shared types and helpers for the Avalon-MM framebuffer agent.
package avalon_agent_pkg;

  // The agent is built on 32-bit words, so each word spans four byte addresses.
  localparam int DATA_WIDTH_DFLT = 32;
  localparam int WORD_BYTES      = DATA_WIDTH_DFLT / 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_LAT,
    RD_STREAM,
    WR_BURST
  } state_t;

  // Drop the byte-lane bits of a byte address; the caller truncates to the memory depth.
  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Reads take one cycle. Contents start as mem[i] = i so the bench and the
// video host see a known pattern without a loader.
module fb_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [DATA_WIDTH/8-1:0]       be,
  input  logic [$clog2(MEM_WORDS)-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         q
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef logic [DATA_WIDTH-1:0] mem_t [MEM_WORDS];

  function automatic mem_t init_contents();
    mem_t m;
    for (int i = 0; i < MEM_WORDS; i++) begin
      m[i] = DATA_WIDTH'(i);
    end
    return m;
  endfunction

  mem_t mem = init_contents();

  logic [DATA_WIDTH-1:0] merged;

  // Build the write word from the stored word with only the enabled bytes replaced.
  always_comb begin
    merged = mem[addr];
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // One port: write the merged word and register the old contents as read data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= merged;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/avalon_fb_agent.sv
// Avalon-MM burst agent standing in for the SDRAM framebuffer.
// Serves burst reads with a fixed latency and gap-free data, accepts burst
// writes with byte enables, and can stall new commands with waitrequest.
module avalon_fb_agent
  import avalon_agent_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int BURST_WIDTH  = 5,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic                      read,
  input  logic                      write,
  input  logic [BURST_WIDTH-1:0]    burstcount,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic [DATA_WIDTH-1:0]     writedata,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest,
  output logic                      proto_err
);

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int STALL_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int LAT_W   = $clog2(READ_LATENCY);

  state_t                  state_q, state_d;
  logic [STALL_W-1:0]      stall_q;
  logic [LAT_W-1:0]        lat_q;
  logic [BURST_WIDTH-1:0]  beats_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    proto_q;
  logic                    rdv_q;

  logic [IDX_W-1:0]        cmd_idx;
  logic [BURST_WIDTH-1:0]  eff_bc;
  logic                    idle_ready;
  logic                    accept_rd;
  logic                    accept_wr;
  logic                    ram_we;
  logic [IDX_W-1:0]        ram_addr;
  logic [DATA_WIDTH-1:0]   ram_q;

  // Decode the command inputs and the handshake from the current state.
  always_comb begin
    cmd_idx    = IDX_W'(word_idx(64'(address)));
    eff_bc     = (burstcount == '0) ? BURST_WIDTH'(1) : burstcount;
    idle_ready = (state_q == IDLE) && (stall_q == STALL_W'(WAIT_CYCLES));
    accept_rd  = idle_ready && read;
    accept_wr  = idle_ready && write && !read;
    waitrequest = !reset_n || !(idle_ready || (state_q == WR_BURST));
    ram_we     = reset_n && (accept_wr || ((state_q == WR_BURST) && write));
    ram_addr   = (state_q == IDLE) ? cmd_idx : idx_q;
  end

  // Next-state logic for the read/write burst sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_rd) begin
          state_d = RD_LAT;
        end else if (accept_wr && (eff_bc > BURST_WIDTH'(1))) begin
          state_d = WR_BURST;
        end
      end
      RD_LAT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 2)) begin
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (beats_q == BURST_WIDTH'(1)) begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (write && (beats_q == BURST_WIDTH'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the read-valid pipeline that lines up with the RAM's registered output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdv_q   <= (state_q == RD_STREAM);
    end
  end

  // Count stalled IDLE cycles of a pending command and measure the read latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      lat_q   <= '0;
    end else begin
      if (accept_rd || accept_wr) begin
        stall_q <= '0;
      end else if ((state_q == IDLE) && (read || write) && !idle_ready) begin
        stall_q <= stall_q + STALL_W'(1);
      end
      if (state_q == RD_LAT) begin
        lat_q <= lat_q + LAT_W'(1);
      end else begin
        lat_q <= '0;
      end
    end
  end

  // Track the word index and the beats still owed for the burst in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q   <= '0;
      beats_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_rd) begin
            idx_q   <= cmd_idx;
            beats_q <= eff_bc;
          end else if (accept_wr) begin
            idx_q   <= cmd_idx + IDX_W'(1);
            beats_q <= eff_bc - BURST_WIDTH'(1);
          end
        end
        RD_STREAM: begin
          idx_q   <= idx_q + IDX_W'(1);
          beats_q <= beats_q - BURST_WIDTH'(1);
        end
        WR_BURST: begin
          if (write) begin
            idx_q   <= idx_q + IDX_W'(1);
            beats_q <= beats_q - BURST_WIDTH'(1);
          end
        end
        default: begin
          idx_q   <= idx_q;
          beats_q <= beats_q;
        end
      endcase
    end
  end

  // Latch any protocol violation until the next reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      proto_q <= 1'b0;
    end else if (((accept_rd || accept_wr) && (burstcount == '0)) ||
                 (idle_ready && read && write) ||
                 ((state_q == WR_BURST) && read)) begin
      proto_q <= 1'b1;
    end
  end

  fb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (byteenable),
    .addr  (ram_addr),
    .wdata (writedata),
    .q     (ram_q)
  );

  assign readdata      = rdv_q ? ram_q : '0;
  assign readdatavalid = rdv_q;
  assign proto_err     = proto_q;

endmodule

// File: tb/tb_avalon_fb_agent.sv
// Scoreboard bench for avalon_fb_agent: one instance with no stalls and one
// with three wait cycles, sharing the command bus through a select bit.
module tb_avalon_fb_agent;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [4:0]  burstcount;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        use2;

  logic [31:0] readdata1, readdata2;
  logic        readdatavalid1, readdatavalid2;
  logic        waitrequest1, waitrequest2;
  logic        proto_err1, proto_err2;

  logic [31:0] mon_data;
  logic        mon_rdv;
  logic        mon_wait;
  logic        mon_pe;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mdl [MEM_WORDS];
  logic [31:0] cyc = '0;
  int          total = 0;
  int          bad = 0;

  avalon_fb_agent #(.WAIT_CYCLES(0)) dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read & ~use2),
    .write         (write & ~use2),
    .burstcount    (burstcount),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata1),
    .readdatavalid (readdatavalid1),
    .waitrequest   (waitrequest1),
    .proto_err     (proto_err1)
  );

  avalon_fb_agent #(.WAIT_CYCLES(3)) dut2 (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read & use2),
    .write         (write & use2),
    .burstcount    (burstcount),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata2),
    .readdatavalid (readdatavalid2),
    .waitrequest   (waitrequest2),
    .proto_err     (proto_err2)
  );

  assign mon_data = use2 ? readdata2 : readdata1;
  assign mon_rdv  = use2 ? readdatavalid2 : readdatavalid1;
  assign mon_wait = use2 ? waitrequest2 : waitrequest1;
  assign mon_pe   = use2 ? proto_err2 : proto_err1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%h required=0x%h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Monitor: every valid beat from the selected agent must match the oldest expectation, in data and in cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_rdv) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_beat: actual data=0x%h required no valid beat", mon_data);
      end else begin
        e = expq.pop_front();
        checkOutput("rd_data", mon_data, e.data);
        checkOutput("rd_cycle", cyc, e.cyc);
      end
    end
    if (use2 ? readdatavalid1 : readdatavalid2) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_agent_beat: actual valid=1 required valid=0 on unselected agent");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    read = 1'b0;
    write = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_waitrequest", {31'd0, mon_wait}, 32'd1);
    checkOutput("rst_valid", {31'd0, mon_rdv}, 32'd0);
    checkOutput("rst_readdata", mon_data, 32'd0);
    checkOutput("rst_proto_err", {31'd0, mon_pe}, 32'd0);
    tick();
    reset_n = 1'b1;
  endtask

  // Issue one command, wait out the stall, and for reads queue the expected beats and check waitrequest.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input int bc,
                               input logic [3:0] be, input logic [31:0] data, input int exp_stall);
    int stalls;
    bit got;
    int w;
    int bce;
    logic [31:0] a_cyc;
    int hi;
    stalls = 0;
    got = 1'b0;
    w = int'(addr[11:2]);
    bce = (bc == 0) ? 1 : bc;
    read = rd;
    write = wr;
    address = addr;
    burstcount = bc[4:0];
    byteenable = be;
    writedata = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!mon_wait) begin
        got = 1'b1;
        break;
      end
      stalls++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: actual=no accept required=accept within 50 cycles");
      read = 1'b0;
      write = 1'b0;
      return;
    end
    checkOutput("stall_cycles", stalls, exp_stall);
    @(posedge clk);
    #1;
    a_cyc = cyc;
    read = 1'b0;
    write = 1'b0;
    if (wr && !rd) begin
      mdl[w] = merge(mdl[w], data, be);
    end
    if (rd) begin
      for (int k = 0; k < bce; k++) begin
        expq.push_back('{mdl[10'(w + k)], a_cyc + 32'(2 + k)});
      end
      hi = 0;
      for (int i = 0; i < bce + 1; i++) begin
        @(negedge clk);
        if (mon_wait) hi++;
      end
      checkOutput("wait_high_cycles", hi, bce + 1);
      @(negedge clk);
      checkOutput("wait_after_burst", {31'd0, mon_wait}, (exp_stall != 0) ? 32'd1 : 32'd0);
      for (int i = 0; i < 40; i++) begin
        if (expq.size() == 0) break;
        @(negedge clk);
      end
      checkOutput("beats_outstanding", expq.size(), 0);
      tick();
    end
  endtask

  // Write burst with a one-cycle bubble before beat 2 and an optional stray read on beat 1.
  task automatic writeBurst(input logic [31:0] addr, input int bc, input logic [3:0] be,
                            input logic [31:0] data, input bit rd_mid);
    int w;
    w = int'(addr[11:2]);
    applyStimulus(1'b0, 1'b1, addr, bc, be, data, 0);
    for (int j = 1; j < bc; j++) begin
      if (j == 2) begin
        write = 1'b0;
        tick();
      end
      write = 1'b1;
      writedata = data;
      read = rd_mid && (j == 1);
      @(negedge clk);
      checkOutput("wr_burst_wait", {31'd0, mon_wait}, 32'd0);
      @(posedge clk);
      #1;
      mdl[10'(w + j)] = merge(mdl[10'(w + j)], data, be);
      read = 1'b0;
      write = 1'b0;
    end
    tick();
  endtask

  initial begin
    logic [31:0] a;
    use2 = 1'b0;
    reset_n = 1'b0;
    read = 1'b0;
    write = 1'b0;
    address = '0;
    burstcount = '0;
    byteenable = '0;
    writedata = '0;
    for (int i = 0; i < MEM_WORDS; i++) mdl[i] = 32'(i);

    resetDut();
    @(negedge clk);
    checkOutput("idle_waitrequest", {31'd0, mon_wait}, 32'd0);
    tick();

    $display("[TB] T1 read addr 0 bc 16");
    applyStimulus(1'b1, 1'b0, 32'h0, 16, 4'h0, 32'h0, 0);

    $display("[TB] T2 read wrapping past word 1023");
    applyStimulus(1'b1, 1'b0, 32'hFF0, 8, 4'h0, 32'h0, 0);

    $display("[TB] T3 byte-enabled write burst and read back");
    writeBurst(32'h40, 4, 4'h3, 32'hAABBCCDD, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h40, 4, 4'h0, 32'h0, 0);

    $display("[TB] T5 reset after the fifth beat");
    read = 1'b1;
    address = 32'h0;
    burstcount = 5'd16;
    @(negedge clk);
    checkOutput("t5_accept_wait", {31'd0, mon_wait}, 32'd0);
    @(posedge clk);
    #1;
    a = cyc;
    read = 1'b0;
    for (int k = 0; k < 5; k++) expq.push_back('{32'(k), a + 32'(2 + k)});
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_valid_after_reset", {31'd0, mon_rdv}, 32'd0);
    checkOutput("t5_beats_left", expq.size(), 0);
    repeat (20) @(negedge clk);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 2, 4'h0, 32'h0, 0);
    checkOutput("t5_proto_err", {31'd0, mon_pe}, 32'd0);

    $display("[TB] read during write burst");
    writeBurst(32'h100, 2, 4'hF, 32'h12345678, 1'b1);
    checkOutput("wr_read_proto_err", {31'd0, mon_pe}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h100, 2, 4'h0, 32'h0, 0);
    resetDut();
    tick();

    $display("[TB] T6 read and write together");
    applyStimulus(1'b1, 1'b1, 32'h8, 1, 4'hF, 32'hDEADBEEF, 0);
    checkOutput("t6_proto_err", {31'd0, mon_pe}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h8, 1, 4'h0, 32'h0, 0);
    checkOutput("t6_proto_err_sticky", {31'd0, mon_pe}, 32'd1);

    $display("[TB] T4 three wait cycles");
    use2 = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 16, 4'h0, 32'h0, 3);
    checkOutput("t4_proto_err", {31'd0, mon_pe}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h80, 0, 4'h0, 32'h0, 3);
    checkOutput("bc0_proto_err", {31'd0, mon_pe}, 32'd1);

    repeat (5) tick();
    checkOutput("final_queue", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
